// File: rtl/spawn_bullets_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_bullets_pkg
//  Description : Shared definitions for the bullet RAM layout. It is used by
//                spawn_bullets (producer) and draw_bullets (consumer).
//                Contents: record byte offsets, pool bounds, playfield limits,
//                movement bit positions and the ring direction table.
//  Revision    : 1.0 - initial release
// ============================================================================
package spawn_bullets_pkg;

  // Byte offsets within a 4-byte bullet record
  localparam logic [1:0] OFS_STAT = 2'd0;
  localparam logic [1:0] OFS_MOV  = 2'd1;
  localparam logic [1:0] OFS_X    = 2'd2;
  localparam logic [1:0] OFS_Y    = 2'd3;

  // Default pool bounds (slot numbers) and playfield limits
  localparam int unsigned POOL_E_FIRST_DEF = 0;
  localparam int unsigned POOL_E_LAST_DEF  = 47;
  localparam int unsigned POOL_P_FIRST_DEF = 48;
  localparam int unsigned POOL_P_LAST_DEF  = 63;
  localparam int unsigned X_MAX_DEF        = 159;
  localparam int unsigned Y_MAX_DEF        = 119;

  // Movement nibble bit positions: {+x, -x, +y, -y}
  localparam int unsigned MOV_PX = 3;
  localparam int unsigned MOV_NX = 2;
  localparam int unsigned MOV_PY = 1;
  localparam int unsigned MOV_NY = 0;

  // Status byte of a live record
  localparam logic [7:0] STAT_ACTIVE = 8'h01;

  // Number of bullets in a ring
  localparam logic [3:0] RING_COUNT = 4'd8;

  // Ring direction k, walking clockwise from +x
  function automatic logic [3:0] ring_dir(input logic [2:0] k);
    logic [3:0] d;
    d = 4'b0000;
    case (k)
      3'd0: d = 4'b1000;
      3'd1: d = 4'b1010;
      3'd2: d = 4'b0010;
      3'd3: d = 4'b0110;
      3'd4: d = 4'b0100;
      3'd5: d = 4'b0101;
      3'd6: d = 4'b0001;
      3'd7: d = 4'b1001;
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_bullets.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_bullets
//  Description : Finds a free record in the enemy or player pool of the
//                bullet RAM and writes one bullet or an 8-direction ring.
//  Ports       : clk, reset (async, active-high)
//                begin_spawn/player/ring/move/org_x/org_y  - request
//                DataOut                                   - RAM read data
//                address/WriteData/RamWrite                - RAM write port
//                done/full/bad_org/spawned                 - request status
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_bullets
  import spawn_bullets_pkg::*;
#(
  parameter int unsigned POOL_E_FIRST = POOL_E_FIRST_DEF,
  parameter int unsigned POOL_E_LAST  = POOL_E_LAST_DEF,
  parameter int unsigned POOL_P_FIRST = POOL_P_FIRST_DEF,
  parameter int unsigned POOL_P_LAST  = POOL_P_LAST_DEF,
  parameter int unsigned X_MAX        = X_MAX_DEF,
  parameter int unsigned Y_MAX        = Y_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       begin_spawn,
  input  logic       player,
  input  logic       ring,
  input  logic [3:0] move,
  input  logic [7:0] org_x,
  input  logic [6:0] org_y,
  input  logic [7:0] DataOut,
  output logic [7:0] address,
  output logic [7:0] WriteData,
  output logic       RamWrite,
  output logic       done,
  output logic       full,
  output logic       bad_org,
  output logic [3:0] spawned
);

  localparam logic [5:0] E_FIRST = 6'(POOL_E_FIRST);
  localparam logic [5:0] E_LAST  = 6'(POOL_E_LAST);
  localparam logic [5:0] P_FIRST = 6'(POOL_P_FIRST);
  localparam logic [5:0] P_LAST  = 6'(POOL_P_LAST);
  localparam logic [6:0] E_SIZE  = 7'(POOL_E_LAST - POOL_E_FIRST + 1);
  localparam logic [6:0] P_SIZE  = 7'(POOL_P_LAST - POOL_P_FIRST + 1);
  localparam logic [7:0] XMAX_C  = 8'(X_MAX);
  localparam logic [6:0] YMAX_C  = 7'(Y_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_WAIT, S_CHECK, S_WR_MOV,
    S_WR_X, S_WR_Y, S_WR_STAT, S_NEXT, S_DONE
  } state_t;

  state_t     state_q;
  logic       player_q, ring_q;
  logic [3:0] move_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [5:0] slot_q, hint_e_q, hint_p_q;
  logic [6:0] checked_q;
  logic [7:0] address_q, wdata_q;
  logic       ramwrite_q, done_q, full_q, bad_org_q;
  logic [3:0] spawned_q;

  logic [5:0] slot_adv;
  logic [6:0] pool_size;
  logic [3:0] mov_sel;
  logic       unused_data;

  // Next slot in the active pool, wrapping from last back to first
  always_comb begin
    slot_adv = slot_q + 6'd1;
    if (player_q) begin
      if (slot_q == P_LAST) slot_adv = P_FIRST;
    end else begin
      if (slot_q == E_LAST) slot_adv = E_FIRST;
    end
  end

  assign pool_size   = player_q ? P_SIZE : E_SIZE;
  // Ring bullets take their direction from the count already written
  assign mov_sel     = ring_q ? ring_dir(spawned_q[2:0]) : move_q;
  assign unused_data = ^DataOut[7:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      player_q   <= 1'b0;
      ring_q     <= 1'b0;
      move_q     <= 4'd0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      slot_q     <= 6'd0;
      hint_e_q   <= E_FIRST;
      hint_p_q   <= P_FIRST;
      checked_q  <= 7'd0;
      address_q  <= 8'd0;
      wdata_q    <= 8'd0;
      ramwrite_q <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      bad_org_q  <= 1'b0;
      spawned_q  <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: if (begin_spawn) state_q <= S_LATCH;
        S_LATCH: begin
          player_q  <= player;
          ring_q    <= ring;
          move_q    <= move;
          x_q       <= org_x;
          y_q       <= org_y;
          full_q    <= 1'b0;
          spawned_q <= 4'd0;
          if (org_x > XMAX_C || org_y > YMAX_C) begin
            bad_org_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            bad_org_q <= 1'b0;
            done_q    <= 1'b0;
            slot_q    <= player ? hint_p_q : hint_e_q;
            address_q <= {(player ? hint_p_q : hint_e_q), OFS_STAT};
            checked_q <= 7'd0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: state_q <= S_CHECK;
        S_CHECK: begin
          if (!DataOut[0]) begin
            address_q  <= {slot_q, OFS_MOV};
            wdata_q    <= {4'd0, mov_sel};
            ramwrite_q <= 1'b1;
            state_q    <= S_WR_MOV;
          end else if (checked_q + 7'd1 == pool_size) begin
            full_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            checked_q <= checked_q + 7'd1;
            slot_q    <= slot_adv;
            address_q <= {slot_adv, OFS_STAT};
            state_q   <= S_WAIT;
          end
        end
        S_WR_MOV: begin
          address_q <= {slot_q, OFS_X};
          wdata_q   <= x_q;
          state_q   <= S_WR_X;
        end
        S_WR_X: begin
          address_q <= {slot_q, OFS_Y};
          wdata_q   <= {1'b0, y_q};
          state_q   <= S_WR_Y;
        end
        // Status goes last so a torn record never looks active
        S_WR_Y: begin
          address_q <= {slot_q, OFS_STAT};
          wdata_q   <= STAT_ACTIVE;
          state_q   <= S_WR_STAT;
        end
        S_WR_STAT: begin
          ramwrite_q <= 1'b0;
          state_q    <= S_NEXT;
        end
        S_NEXT: begin
          spawned_q <= spawned_q + 4'd1;
          if (player_q) hint_p_q <= slot_adv;
          else          hint_e_q <= slot_adv;
          if (ring_q && (spawned_q + 4'd1 < RING_COUNT)) begin
            // The slot just written counts toward the pool scan
            if (checked_q + 7'd1 == pool_size) begin
              full_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              checked_q <= checked_q + 7'd1;
              slot_q    <= slot_adv;
              address_q <= {slot_adv, OFS_STAT};
              state_q   <= S_WAIT;
            end
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!begin_spawn) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address   = address_q;
  assign WriteData = wdata_q;
  assign RamWrite  = ramwrite_q;
  assign done      = done_q;
  assign full      = full_q;
  assign bad_org   = bad_org_q;
  assign spawned   = spawned_q;

endmodule
`default_nettype wire
